// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// opcode constants, FSM state encoding and access-size decode helpers.
package dmem_access_ctrl_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWU = 6'b100111;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef struct packed {
    logic  is_mem;
    logic  is_load;
    size_t size;
  } acc_t;

  // Classify an opcode; anything outside the load/store set is not a memory op.
  function automatic acc_t decode_op(input logic [5:0] op);
    acc_t a;
    a.is_mem  = 1'b1;
    a.is_load = 1'b1;
    a.size    = SZ_BYTE;
    case (op)
      OP_LB, OP_LBU: a.size = SZ_BYTE;
      OP_LH, OP_LHU: a.size = SZ_HALF;
      OP_LW, OP_LWU: a.size = SZ_WORD;
      OP_SB: begin a.is_load = 1'b0; a.size = SZ_BYTE; end
      OP_SH: begin a.is_load = 1'b0; a.size = SZ_HALF; end
      OP_SW: begin a.is_load = 1'b0; a.size = SZ_WORD; end
      default: begin a.is_mem = 1'b0; a.is_load = 1'b0; end
    endcase
    return a;
  endfunction

  // Signed loads (LB/LH/LW) have opcode bit 2 clear; the extender uses this.
  function automatic logic is_signed_load(input logic [5:0] op);
    return (op[5:3] == 3'b100) && !op[2];
  endfunction

  // Halves must be 2-byte aligned, words 4-byte aligned.
  function automatic logic misaligned(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_lane_align.sv
// dmem_lane_align: combinational little-endian lane steering. Produces byte
// enables and lane-replicated store data for the request, and right-shifts
// the returned read word so the addressed byte/halfword lands at bit 0.
module dmem_lane_align
  import dmem_access_ctrl_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  off_req,
  input  logic [31:0] wdata,
  input  logic [1:0]  off_rsp,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_shift
);

  // Byte enables follow access size shifted to the addressed lane.
  always_comb begin
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << off_req;
      SZ_HALF: be = 4'b0011 << off_req;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Each lane picks the store byte that would land there for this size.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_lane[8*gi +: 8] = (size == SZ_BYTE) ? wdata[7:0] :
                                   (size == SZ_HALF) ? wdata[8*(gi%2) +: 8] :
                                                       wdata[8*gi +: 8];
  end

  assign rdata_shift = rdata >> {off_rsp, 3'b000};

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage load/store controller. Issues a registered,
// word-aligned, byte-enabled memory request, stalls the pipeline until
// mem_ack, then presents the lane-aligned read word for the load extender.
// Optional ack watchdog enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [5:0]  instruccion,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic [5:0]  instruccion_out,
  output logic        addr_err,
  output logic        bus_err
);

  state_t      state_reg, state_next;
  acc_t        acc;
  logic        mis;
  logic        accept;
  logic        tmo_hit;
  logic [3:0]  be_lane;
  logic [31:0] wdata_lane;
  logic [31:0] rdata_shift;

  logic        mem_req_reg, mem_we_reg;
  logic [3:0]  mem_be_reg;
  logic [31:0] mem_addr_reg, mem_wdata_reg, ld_data_reg;
  logic [1:0]  off_reg;
  logic        is_load_reg;
  logic        ld_valid_reg, bus_err_reg;
  logic [5:0]  instr_reg;

  assign acc = decode_op(instruccion);
  assign mis = misaligned(acc.size, addr[1:0]);

  dmem_lane_align u_align (
    .size        (acc.size),
    .off_req     (addr[1:0]),
    .wdata       (wdata),
    .off_rsp     (off_reg),
    .rdata       (mem_rdata),
    .be          (be_lane),
    .wdata_lane  (wdata_lane),
    .rdata_shift (rdata_shift)
  );

`ifdef DMEM_TIMEOUT_EN
  logic [31:0] tmo_cnt_reg;

  // Watchdog counts WAIT cycles; restarted each time a request is accepted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_cnt_reg <= '0;
    end else if (accept) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == ST_WAIT) begin
      tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
    end
  end

  assign tmo_hit = (state_reg == ST_WAIT) && !mem_ack &&
                   (tmo_cnt_reg == 32'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Next state, accept/misalign decode and the combinational stall.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    addr_err   = 1'b0;
    if (reset_n && state_reg == ST_IDLE && req_valid && acc.is_mem) begin
      accept   = !mis;
      addr_err = mis;
    end
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_WAIT;
      ST_WAIT: if (mem_ack || tmo_hit) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    stall = accept || (state_reg == ST_WAIT);
  end

  // Request latch on accept, completion capture on ack or watchdog expiry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_be_reg    <= 4'b0000;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      ld_data_reg   <= '0;
      off_reg       <= 2'b00;
      is_load_reg   <= 1'b0;
      ld_valid_reg  <= 1'b0;
      bus_err_reg   <= 1'b0;
      instr_reg     <= 6'b000000;
    end else begin
      ld_valid_reg <= 1'b0;
      bus_err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= !acc.is_load;
            mem_be_reg    <= be_lane;
            mem_addr_reg  <= {addr[31:2], 2'b00};
            mem_wdata_reg <= wdata_lane;
            off_reg       <= addr[1:0];
            is_load_reg   <= acc.is_load;
            instr_reg     <= instruccion;
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
            if (is_load_reg) begin
              ld_data_reg  <= rdata_shift;
              ld_valid_reg <= 1'b1;
            end
          end else if (tmo_hit) begin
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
            bus_err_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req         = mem_req_reg;
  assign mem_we          = mem_we_reg;
  assign mem_be          = mem_be_reg;
  assign mem_addr        = mem_addr_reg;
  assign mem_wdata       = mem_wdata_reg;
  assign ld_data         = ld_data_reg;
  assign ld_valid        = ld_valid_reg;
  assign instruccion_out = instr_reg;
  assign bus_err         = bus_err_reg;

endmodule
